rot_detect8: RTL and testbench



---
 rtl/rot_detect8.sv | 102 ++++++++++
 tb/tb_rot_detect8.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rot_detect8.sv
// Rotation detector: finds the left/right rotation mapping original onto
// rotated, trying one left rotation per clock.
module rot_detect8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] original,
  input  logic [WIDTH-1:0] rotated,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [2:0]       shift,
  output logic             right
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] target;
  logic [2:0]       cnt;

  logic             hit;
  logic             last;
  logic [WIDTH-1:0] work_rotl;
  logic             use_right;
  logic [2:0]       amt;

  assign hit       = (work == target);
  assign last      = (cnt == 3'd7);
  assign work_rotl = {work[WIDTH-2:0], work[WIDTH-1]};
  assign use_right = (cnt > 3'd4);
  // Left by k equals right by 8-k; 3-bit negate gives 8-k for k in 5..7.
  assign amt       = use_right ? (3'd0 - cnt) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      found     <= 1'b0;
      shift     <= 3'd0;
      right     <= 1'b0;
      work      <= '0;
      target    <= '0;
      cnt       <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= original;
            target   <= rotated;
            cnt      <= 3'd0;
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            found     <= 1'b1;
            shift     <= amt;
            right     <= use_right;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (last) begin
            found     <= 1'b0;
            shift     <= 3'd0;
            right     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            work <= work_rotl;
            cnt  <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            found     <= 1'b0;
            shift     <= 3'd0;
            right     <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rot_detect8.sv
// Bench for rot_detect8: directed cases plus random jobs against a
// rotation-search reference model.
module tb_rot_detect8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] original;
  logic [7:0] rotated;
  logic       out_valid;
  logic       out_ready;
  logic       found;
  logic [2:0] shift;
  logic       right;

  int total = 0;
  int bad   = 0;

  rot_detect8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .original (original),
    .rotated  (rotated),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .found    (found),
    .shift    (shift),
    .right    (right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    int x;
    x = int'(v);
    return 8'(((x << k) | (x >> (8 - k))) & 255);
  endfunction

  // Reference: smallest left amount k that maps o onto r.
  task automatic model(input logic [7:0] o, input logic [7:0] r,
                       output int ef, output int es, output int er,
                       output int elat);
    int k;
    k = -1;
    for (int i = 0; i < 8; i++)
      if (k < 0 && rotl(o, i) == r) k = i;
    if (k < 0) begin
      ef = 0; es = 0; er = 0; elat = 8;
    end else begin
      ef = 1;
      es = (k <= 4) ? k : 8 - k;
      er = (k <= 4) ? 0 : 1;
      elat = k + 1;
    end
  endtask

  task automatic run_job(input logic [7:0] o, input logic [7:0] r,
                         input int hold, input string tag);
    int ef, es, er, elat, lat, w;
    model(o, r, ef, es, er, elat);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    original = o;
    rotated  = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    original = 8'($urandom);
    rotated  = 8'($urandom);
    chk({tag, " busy"}, int'(in_ready), 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({tag, " lat"}, lat, elat);
    chk({tag, " found"}, int'(found), ef);
    chk({tag, " shift"}, int'(shift), es);
    chk({tag, " right"}, int'(right), er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      original = 8'($urandom);
      rotated  = 8'($urandom);
      @(posedge clk);
      #1;
      chk({tag, " hold valid"}, int'(out_valid), 1);
      chk({tag, " hold ready"}, int'(in_ready), 0);
      chk({tag, " hold res"}, {found, shift, right}, {ef[0], es[2:0], er[0]});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " release ready"}, int'(in_ready), 1);
    chk({tag, " release valid"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [7:0] o, r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    original  = 8'h00;
    rotated   = 8'h00;
    #12;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst result", {found, shift, right}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(8'hB1, 8'h8D, 0, "rotl3");
    run_job(8'hB1, 8'h6C, 0, "rotr2");
    run_job(8'hB1, 8'h1B, 0, "tie4");
    run_job(8'h55, 8'h55, 0, "p55");
    run_job(8'h55, 8'hAA, 0, "p55aa");
    run_job(8'h00, 8'h00, 0, "zero");
    run_job(8'hFF, 8'hFF, 0, "ones");
    run_job(8'h01, 8'h03, 0, "nomatch");
    run_job(8'hB1, 8'h8D, 5, "bp");

    // Abandon a job mid-search with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    original = 8'hB1;
    rotated  = 8'h6C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-rst busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("arst in_ready", int'(in_ready), 1);
    chk("arst out_valid", int'(out_valid), 0);
    chk("arst result", {found, shift, right}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(8'h0F, 8'hF0, 0, "post-rst");

    for (int n = 0; n < 40; n++) begin
      o = 8'($urandom);
      if (n % 2 == 0) r = rotl(o, int'($urandom_range(0, 7)));
      else r = 8'($urandom);
      run_job(o, r, int'($urandom_range(0, 2)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
